wired_inst_queue: RTL and testbench

Decoupling instruction queue at the frontend/backend boundary. It accepts up to two decoded instructions per cycle from the decoder and buffers them in an in-order circular store. It presents up to two oldest instructions per cycle to the backend rename stage as a masked 2-wide packet and absorbs backend stalls. It is the transmitting end of the `pkg_valid`/`pkg_ready`/`pkg_mask`/`pkg` interface consumed by the backend.

---
 rtl/wired_inst_queue.sv | 65 ++++++
 tb/tb_wired_inst_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wired_inst_queue.sv
// wired_inst_queue: in-order circular buffer taking and presenting up to two instructions per cycle
module wired_inst_queue #(
    parameter int DEPTH = 8,
    parameter int W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [1:0]              in_mask_i,
    input  logic [2*W-1:0]          in_pkg_i,
    output logic                    pkg_valid_o,
    input  logic                    pkg_ready_i,
    output logic [1:0]              pkg_mask_o,
    output logic [2*W-1:0]          pkg_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LIM = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0] TWO = (AW+1)'(2);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head, tail, head1, tail1;
    logic [AW:0]   count;
    logic          enq, deq;
    logic [1:0]    enq_n, deq_n;
    logic [W-1:0]  wr0, wr1;

    // handshakes, compaction of the input packet and masked output view, all from registered state
    always_comb begin
        head1       = head + 1'b1;
        tail1       = tail + 1'b1;
        in_ready_o  = count <= LIM;
        enq         = in_valid_i && in_ready_o && !flush_i;
        enq_n       = enq ? {1'b0, in_mask_i[0]} + {1'b0, in_mask_i[1]} : 2'd0;
        wr0         = in_mask_i[0] ? in_pkg_i[W-1:0] : in_pkg_i[2*W-1:W];
        wr1         = in_pkg_i[2*W-1:W];
        pkg_mask_o  = {count >= TWO, count != '0};
        pkg_valid_o = pkg_mask_o[0];
        pkg_o       = {pkg_mask_o[1] ? mem[head1] : {W{1'b0}}, pkg_mask_o[0] ? mem[head] : {W{1'b0}}};
        deq         = pkg_valid_o && pkg_ready_i && !flush_i;
        deq_n       = deq ? (pkg_mask_o[1] ? 2'd2 : 2'd1) : 2'd0;
        count_o     = count;
    end

    // pointer and occupancy update; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(deq_n);
            tail  <= tail + AW'(enq_n);
            count <= count + (AW+1)'(enq_n) - (AW+1)'(deq_n);
        end
    end

    // entry storage is not reset; valid slots are written compacted at tail, tail+1
    always_ff @(posedge clk) begin
        if (enq && in_mask_i != 2'b00) mem[tail] <= wr0;
        if (enq && in_mask_i == 2'b11) mem[tail1] <= wr1;
    end
endmodule

// File: tb/tb_wired_inst_queue.sv
// tb_wired_inst_queue: directed scenario checks of the 2-wide instruction queue
module tb_wired_inst_queue;
    localparam int DEPTH = 8;
    localparam int W = 32;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          flush_i = 0;
    logic          in_valid_i = 0;
    logic          in_ready_o;
    logic [1:0]    in_mask_i = 0;
    logic [2*W-1:0] in_pkg_i = 0;
    logic          pkg_valid_o;
    logic          pkg_ready_i = 0;
    logic [1:0]    pkg_mask_o;
    logic [2*W-1:0] pkg_o;
    logic [3:0]    count_o;

    int tests = 0;
    int fails = 0;

    wired_inst_queue #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_mask_i(in_mask_i), .in_pkg_i(in_pkg_i),
        .pkg_valid_o(pkg_valid_o), .pkg_ready_i(pkg_ready_i),
        .pkg_mask_o(pkg_mask_o), .pkg_o(pkg_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] m, input logic [W-1:0] s1, input logic [W-1:0] s0);
        in_valid_i = 1;
        in_mask_i  = m;
        in_pkg_i   = {s1, s0};
        step();
        in_valid_i = 0;
        in_mask_i  = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        tests++; if (pkg_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", pkg_valid_o); end
        tests++; if (pkg_mask_o !== 2'b00) begin fails++; $display("FAIL reset_mask got %b exp 00", pkg_mask_o); end
        tests++; if (pkg_o !== '0) begin fails++; $display("FAIL reset_pkg got %h exp 0", pkg_o); end
        tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready_o); end
        step();
        tests++; if (pkg_valid_o !== 1'b0) begin fails++; $display("FAIL idle_valid got %b exp 0", pkg_valid_o); end
    endtask

    task automatic test_basic();
        offer(2'b11, 32'hB0B0_0002, 32'hA0A0_0001);
        tests++; if (pkg_mask_o !== 2'b11) begin fails++; $display("FAIL basic_mask got %b exp 11", pkg_mask_o); end
        tests++; if (pkg_o !== {32'hB0B0_0002, 32'hA0A0_0001}) begin fails++; $display("FAIL basic_pkg got %h exp b0b00002a0a00001", pkg_o); end
        tests++; if (count_o !== 4'd2) begin fails++; $display("FAIL basic_count got %0d exp 2", count_o); end
        pkg_ready_i = 1;
        step();
        pkg_ready_i = 0;
        tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL basic_drain_count got %0d exp 0", count_o); end
        tests++; if (pkg_valid_o !== 1'b0) begin fails++; $display("FAIL basic_drain_valid got %b exp 0", pkg_valid_o); end
    endtask

    task automatic test_odd_masks();
        offer(2'b01, 32'hDEAD_DEAD, 32'h0000_00A1);
        offer(2'b10, 32'h0000_00B2, 32'hDEAD_DEAD);
        offer(2'b01, 32'hDEAD_DEAD, 32'h0000_00C3);
        tests++; if (pkg_o !== {32'h0000_00B2, 32'h0000_00A1}) begin fails++; $display("FAIL odd_pkg got %h exp 000000b2000000a1", pkg_o); end
        tests++; if (count_o !== 4'd3) begin fails++; $display("FAIL odd_count got %0d exp 3", count_o); end
        pkg_ready_i = 1;
        step();
        pkg_ready_i = 0;
        tests++; if (pkg_o !== {32'h0, 32'h0000_00C3}) begin fails++; $display("FAIL odd_tail_pkg got %h exp 00000000000000c3", pkg_o); end
        tests++; if (pkg_mask_o !== 2'b01) begin fails++; $display("FAIL odd_tail_mask got %b exp 01", pkg_mask_o); end
        pkg_ready_i = 1;
        step();
        pkg_ready_i = 0;
        tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL odd_drain got %0d exp 0", count_o); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL fill_ready_%0d got %b exp 1", i, in_ready_o); end
            offer(2'b11, 32'(16 + 2*i + 1), 32'(16 + 2*i));
        end
        tests++; if (count_o !== 4'd8) begin fails++; $display("FAIL fill_count got %0d exp 8", count_o); end
        tests++; if (in_ready_o !== 1'b0) begin fails++; $display("FAIL fill_full_ready got %b exp 0", in_ready_o); end
        offer(2'b11, 32'hEEEE_EEEE, 32'hFFFF_FFFF);
        tests++; if (count_o !== 4'd8) begin fails++; $display("FAIL fill_ignored got %0d exp 8", count_o); end
        in_valid_i = 1;
        in_mask_i = 2'b11;
        in_pkg_i = {32'hEEEE_EEEE, 32'hFFFF_FFFF};
        pkg_ready_i = 1;
        step();
        in_valid_i = 0;
        in_mask_i = 0;
        pkg_ready_i = 0;
        tests++; if (count_o !== 4'd6) begin fails++; $display("FAIL fill_deq_count got %0d exp 6", count_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL fill_deq_ready got %b exp 1", in_ready_o); end
        tests++; if (pkg_o !== {32'd19, 32'd18}) begin fails++; $display("FAIL fill_deq_pkg got %h exp 0000001300000012", pkg_o); end
        pkg_ready_i = 1;
        step(); step(); step();
        pkg_ready_i = 0;
        tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL fill_drain got %0d exp 0", count_o); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] q[$];
        logic [W-1:0] e0, e1;
        logic [1:0]   m;
        int           seq = 256;
        int           n;
        bit           acc;
        offer(2'b01, 32'h0, 32'(seq));
        q.push_back(32'(seq));
        seq++;
        for (int c = 0; c < 40; c++) begin
            m = c < 20 ? 2'($urandom_range(0, 3)) : 2'b00;
            in_valid_i  = c < 20 ? 1'($urandom_range(0, 1)) | (m != 2'b00) : 1'b0;
            pkg_ready_i = c < 20 ? 1'($urandom_range(0, 1)) : 1'b1;
            in_mask_i   = m;
            in_pkg_i    = {32'(seq + 1), 32'(seq)};
            e0 = q.size() >= 1 ? q[0] : '0;
            e1 = q.size() >= 2 ? q[1] : '0;
            tests++; if (count_o !== 4'(q.size())) begin fails++; $display("FAIL wrap_count_%0d got %0d exp %0d", c, count_o, q.size()); end
            tests++; if (pkg_o !== {e1, e0}) begin fails++; $display("FAIL wrap_pkg_%0d got %h exp %h", c, pkg_o, {e1, e0}); end
            tests++; if (in_ready_o !== (q.size() <= DEPTH - 2)) begin fails++; $display("FAIL wrap_ready_%0d got %b exp %b", c, in_ready_o, q.size() <= DEPTH - 2); end
            acc = in_valid_i && q.size() <= DEPTH - 2;
            n = pkg_ready_i ? (q.size() >= 2 ? 2 : q.size()) : 0;
            for (int k = 0; k < n; k++) void'(q.pop_front());
            if (acc) begin
                if (m[0]) q.push_back(32'(seq));
                if (m[1]) q.push_back(32'(seq + 1));
            end
            seq += 2;
            step();
        end
        in_valid_i = 0;
        in_mask_i = 0;
        pkg_ready_i = 0;
        tests++; if (count_o !== 4'd0 || q.size() != 0) begin fails++; $display("FAIL wrap_drained got %0d exp 0", count_o); end
    endtask

    task automatic test_flush();
        offer(2'b11, 32'h12, 32'h11);
        offer(2'b11, 32'h14, 32'h13);
        offer(2'b01, 32'h0, 32'h15);
        tests++; if (count_o !== 4'd5) begin fails++; $display("FAIL flush_pre_count got %0d exp 5", count_o); end
        flush_i = 1;
        pkg_ready_i = 1;
        offer(2'b11, 32'hBAD2, 32'hBAD1);
        flush_i = 0;
        pkg_ready_i = 0;
        tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL flush_count got %0d exp 0", count_o); end
        tests++; if (pkg_valid_o !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", pkg_valid_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL flush_ready got %b exp 1", in_ready_o); end
        offer(2'b01, 32'h0, 32'h5A5A);
        tests++; if (pkg_o !== {32'h0, 32'h5A5A}) begin fails++; $display("FAIL flush_after_pkg got %h exp 0000000000005a5a", pkg_o); end
    endtask

    task automatic test_stall_widen();
        tests++; if (pkg_mask_o !== 2'b01) begin fails++; $display("FAIL widen_pre_mask got %b exp 01", pkg_mask_o); end
        offer(2'b10, 32'h6B6B, 32'h0);
        tests++; if (pkg_mask_o !== 2'b11) begin fails++; $display("FAIL widen_mask got %b exp 11", pkg_mask_o); end
        tests++; if (pkg_o !== {32'h6B6B, 32'h5A5A}) begin fails++; $display("FAIL widen_pkg got %h exp 00006b6b00005a5a", pkg_o); end
        rst_n = 0;
        step();
        rst_n = 1;
        tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL midreset_count got %0d exp 0", count_o); end
        tests++; if (pkg_o !== '0) begin fails++; $display("FAIL midreset_pkg got %h exp 0", pkg_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd_masks();
        test_fill();
        test_wrap();
        test_flush();
        test_stall_widen();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
